// File: rtl/alu_ctrl_if.sv
// Decode-to-execute handshake bundle for the ALU-control stage: decoded instruction fields in,
// registered ALU select / branch resolution out, valid/ready on both sides.
interface alu_ctrl_if #(
  parameter int ALU_CTRL_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            func3;
  logic [6:0]            func7;
  logic                  op5;
  logic                  op4;
  logic [1:0]            alu_op;
  logic                  branch;
  logic                  jlink;
  logic                  zero;
  logic                  lt;
  logic                  ltu;
  logic                  out_valid;
  logic                  out_ready;
  logic [ALU_CTRL_W-1:0] alu_ctrl_o;
  logic                  byte_op_o;
  logic                  pc_src_o;
  logic                  illegal_o;
  logic                  mdu_start_o;
  logic                  mdu_abort_o;

  modport master (
    output in_valid, func3, func7, op5, op4, alu_op, branch, jlink, zero, lt, ltu, out_ready,
    input  in_ready, out_valid, alu_ctrl_o, byte_op_o, pc_src_o, illegal_o, mdu_start_o, mdu_abort_o
  );

  modport slave (
    input  in_valid, func3, func7, op5, op4, alu_op, branch, jlink, zero, lt, ltu, out_ready,
    output in_ready, out_valid, alu_ctrl_o, byte_op_o, pc_src_o, illegal_o, mdu_start_o, mdu_abort_o
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU-control / branch-resolve stage for RV32IM: decodes ALU select, byte_op and pc_src,
// and holds the stage for the MDU latency on multiply/divide operations.
module alu_ctrl_seq #(
  parameter int ALU_CTRL_W = 5,
  parameter int ENABLE_M   = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  alu_ctrl_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MDU  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  localparam logic [ALU_CTRL_W-1:0] C_ADD  = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] C_SUB  = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] C_AND  = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] C_OR   = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] C_XOR  = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] C_SLT  = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] C_SLTU = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] C_SLL  = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] C_SRL  = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] C_SRA  = ALU_CTRL_W'(9);

  typedef struct packed {
    logic [ALU_CTRL_W-1:0] ctrl;
    logic                  byte_op;
    logic                  pc_src;
    logic                  illegal;
    logic                  is_m;
    logic                  is_div;
  } dec_t;

  function automatic dec_t decode(
    input logic [1:0] alu_op,
    input logic [2:0] f3,
    input logic [6:0] f7,
    input logic       op5,
    input logic       branch,
    input logic       jlink,
    input logic       zero,
    input logic       lt,
    input logic       ltu
  );
    dec_t d;
    logic m_enc;
    d     = '0;
    m_enc = (alu_op == 2'b10) && op5 && (f7 == 7'b0000001);
    case (alu_op)
      2'b00: d.ctrl = C_ADD;
      2'b01: d.ctrl = C_SUB;
      2'b11: begin
        d.ctrl    = C_ADD;
        d.byte_op = (f3 == 3'b000);
      end
      default: begin
        case (f3)
          3'b000:  d.ctrl = (op5 && f7[5]) ? C_SUB : C_ADD;
          3'b001:  d.ctrl = C_SLL;
          3'b010:  d.ctrl = C_SLT;
          3'b011:  d.ctrl = C_SLTU;
          3'b100:  d.ctrl = C_XOR;
          3'b101:  d.ctrl = f7[5] ? C_SRA : C_SRL;
          3'b110:  d.ctrl = C_OR;
          default: d.ctrl = C_AND;
        endcase
      end
    endcase
    if (m_enc) begin
      if (ENABLE_M != 0) begin
        d.ctrl   = ALU_CTRL_W'(5'd16 + {2'b00, f3});
        d.is_m   = 1'b1;
        d.is_div = f3[2];
      end else begin
        d.illegal = 1'b1;
      end
    end
    // Jumps always redirect; branch outcome comes from the flags sampled with the fields.
    if (jlink) begin
      d.pc_src = 1'b1;
    end else if (branch) begin
      case (f3)
        3'b000:  d.pc_src = zero;
        3'b001:  d.pc_src = !zero;
        3'b100:  d.pc_src = lt;
        3'b101:  d.pc_src = !lt;
        3'b110:  d.pc_src = ltu;
        3'b111:  d.pc_src = !ltu;
        default: d.illegal = 1'b1;
      endcase
    end
    if (d.illegal) begin
      d.ctrl = '1;
      d.is_m = 1'b0;
    end
    return d;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ALU_CTRL_W-1:0] ctrl_q, ctrl_d;
  logic                  byte_q, byte_d;
  logic                  pc_q, pc_d;
  logic                  ill_q, ill_d;
  logic                  start_q, start_d;
  logic                  abort_q, abort_d;
  dec_t                  dec;
  logic                  accept;
  logic                  unused_op4;

  assign unused_op4 = bus.op4;

  assign dec = decode(bus.alu_op, bus.func3, bus.func7, bus.op5, bus.branch, bus.jlink,
                      bus.zero, bus.lt, bus.ltu);

  // OUT passes out_ready straight through so a consumed result can be replaced without a bubble.
  assign bus.in_ready = (state_q == S_IDLE) || ((state_q == S_OUT) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    byte_d  = byte_q;
    pc_d    = pc_q;
    ill_d   = ill_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      abort_d = (state_q == S_MDU);
    end else if (accept) begin
      ctrl_d = dec.ctrl;
      byte_d = dec.byte_op;
      pc_d   = dec.pc_src;
      ill_d  = dec.illegal;
      if (dec.is_m) begin
        state_d = S_MDU;
        start_d = 1'b1;
        cnt_d   = dec.is_div ? DIV_LAST : MUL_LAST;
      end else begin
        state_d = S_OUT;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_MDU: begin
          if (cnt_q == '0) state_d = S_OUT;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_OUT: begin
          if (bus.out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      byte_q  <= 1'b0;
      pc_q    <= 1'b0;
      ill_q   <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      byte_q  <= byte_d;
      pc_q    <= pc_d;
      ill_q   <= ill_d;
      start_q <= start_d;
      abort_q <= abort_d;
    end
  end

  assign bus.out_valid   = (state_q == S_OUT);
  assign bus.alu_ctrl_o  = ctrl_q;
  assign bus.byte_op_o   = byte_q;
  assign bus.pc_src_o    = pc_q;
  assign bus.illegal_o   = ill_q;
  assign bus.mdu_start_o = start_q;
  assign bus.mdu_abort_o = abort_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: transaction-level reference model checked every cycle, plus directed
// vectors with hand-computed expectations; a second instance covers the ENABLE_M=0 build.
module tb_alu_ctrl_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 1'b0;

  alu_ctrl_if #(.ALU_CTRL_W(5)) b0 ();
  alu_ctrl_if #(.ALU_CTRL_W(5)) b1 ();

  alu_ctrl_seq #(.ALU_CTRL_W(5), .ENABLE_M(1), .MUL_CYCLES(2), .DIV_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (b0.slave)
  );

  alu_ctrl_seq #(.ALU_CTRL_W(5), .ENABLE_M(0), .MUL_CYCLES(2), .DIV_CYCLES(8)) dut_nom (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (b1.slave)
  );

  assign b1.in_valid  = b0.in_valid;
  assign b1.func3     = b0.func3;
  assign b1.func7     = b0.func7;
  assign b1.op5       = b0.op5;
  assign b1.op4       = b0.op4;
  assign b1.alu_op    = b0.alu_op;
  assign b1.branch    = b0.branch;
  assign b1.jlink     = b0.jlink;
  assign b1.zero      = b0.zero;
  assign b1.lt        = b0.lt;
  assign b1.ltu       = b0.ltu;
  assign b1.out_ready = b0.out_ready;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode from the instruction-set rules, table driven.
  function automatic void ref_decode(
    input  logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
    input  logic o5, input logic br, input logic jl, input logic z, input logic l, input logic lu,
    output logic [4:0] ctrl, output logic byt, output logic pc, output logic ill, output int lat
  );
    logic [4:0] arith [8];
    logic       take [8];
    arith = '{5'd0, 5'd7, 5'd5, 5'd6, 5'd4, 5'd8, 5'd3, 5'd2};
    take  = '{z, !z, 1'b0, 1'b0, l, !l, lu, !lu};
    byt = 1'b0; pc = 1'b0; ill = 1'b0; lat = 0;
    if (aop == 2'b10 && o5 && f7 == 7'h01) begin
      ctrl = 5'd16 + {2'b00, f3};
      lat  = f3[2] ? 8 : 2;
    end else if (aop == 2'b00) ctrl = 5'd0;
    else if (aop == 2'b01) ctrl = 5'd1;
    else if (aop == 2'b11) begin
      ctrl = 5'd0;
      byt  = (f3 == 3'b000);
    end else begin
      ctrl = arith[f3];
      if (f3 == 3'b000 && o5 && f7[5]) ctrl = 5'd1;
      if (f3 == 3'b101 && f7[5]) ctrl = 5'd9;
    end
    if (jl) pc = 1'b1;
    else if (br) begin
      pc  = take[f3];
      ill = (f3 == 3'b010 || f3 == 3'b011);
    end
    if (ill) begin
      ctrl = 5'h1f;
      lat  = 0;
    end
  endfunction

  // Model: a stage holds at most one transaction, which becomes visible after lat wait cycles.
  bit         m_have  = 1'b0;
  int         m_wait  = 0;
  logic [4:0] m_ctrl  = '0;
  logic       m_byte  = 1'b0;
  logic       m_pc    = 1'b0;
  logic       m_ill   = 1'b0;
  logic       m_start = 1'b0;
  logic       m_abort = 1'b0;

  function automatic logic exp_in_ready();
    return !m_have || (m_wait == 0 && b0.out_ready);
  endfunction

  initial forever begin : model
    logic [4:0] c;
    logic       by, p, il;
    int         lt_n;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_have = 0; m_wait = 0; m_ctrl = '0; m_byte = 0; m_pc = 0; m_ill = 0;
      m_start = 0; m_abort = 0;
    end else begin
      m_start = 1'b0;
      m_abort = 1'b0;
      if (flush) begin
        m_abort = m_have && (m_wait > 0);
        m_have  = 0;
        m_wait  = 0;
      end else if (b0.in_valid && exp_in_ready()) begin
        ref_decode(b0.alu_op, b0.func3, b0.func7, b0.op5, b0.branch, b0.jlink,
                   b0.zero, b0.lt, b0.ltu, c, by, p, il, lt_n);
        m_ctrl = c; m_byte = by; m_pc = p; m_ill = il;
        m_have = 1; m_wait = lt_n; m_start = (lt_n > 0);
      end else if (m_have && m_wait == 0 && b0.out_ready) begin
        m_have = 0;
      end else if (m_wait > 0) begin
        m_wait = m_wait - 1;
      end
    end
  end

  initial forever begin : compare
    @(negedge clk);
    if (run_cmp) begin
      chk("out_valid", b0.out_valid, m_have && (m_wait == 0));
      chk("in_ready", b0.in_ready, exp_in_ready());
      chk("alu_ctrl", b0.alu_ctrl_o, m_ctrl);
      chk("byte_op", b0.byte_op_o, m_byte);
      chk("pc_src", b0.pc_src_o, m_pc);
      chk("illegal", b0.illegal_o, m_ill);
      chk("mdu_start", b0.mdu_start_o, m_start);
      chk("mdu_abort", b0.mdu_abort_o, m_abort);
    end
  end

  task automatic set_op(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                        input logic o5, input logic br, input logic jl,
                        input logic z, input logic l, input logic lu);
    b0.alu_op = aop; b0.func3 = f3; b0.func7 = f7; b0.op5 = o5; b0.op4 = o5;
    b0.branch = br; b0.jlink = jl; b0.zero = z; b0.lt = l; b0.ltu = lu;
  endtask

  task automatic step();
    @(posedge clk);
    #4;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin : main
    int n;
    int seen;
    b0.in_valid = 0; b0.out_ready = 1;
    set_op(2'b00, 3'b000, 7'h00, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    run_cmp = 1'b1;
    step();
    chk("rst_valid", b0.out_valid, 0);
    chk("rst_ctrl", b0.alu_ctrl_o, 0);
    chk("rst_pc", b0.pc_src_o, 0);
    chk("rst_ill", b0.illegal_o, 0);
    chk("rst_start", b0.mdu_start_o, 0);
    rst_n = 1'b1;
    step();

    // Back-to-back stream of single-cycle ops.
    set_op(2'b10, 3'b000, 7'h20, 1, 0, 0, 0, 0, 0); b0.in_valid = 1; step();
    chk("sub_valid", b0.out_valid, 1);
    chk("sub_ctrl", b0.alu_ctrl_o, 1);
    set_op(2'b01, 3'b001, 7'h00, 1, 1, 0, 0, 0, 0); step();
    chk("bne_pc", b0.pc_src_o, 1);
    set_op(2'b01, 3'b111, 7'h00, 1, 1, 0, 0, 0, 1); step();
    chk("bgeu_pc", b0.pc_src_o, 0);
    set_op(2'b01, 3'b010, 7'h00, 1, 1, 0, 1, 1, 1); step();
    chk("br010_ill", b0.illegal_o, 1);
    chk("br010_pc", b0.pc_src_o, 0);
    chk("br010_ctrl", b0.alu_ctrl_o, 5'h1f);
    set_op(2'b11, 3'b000, 7'h00, 0, 0, 0, 0, 0, 0); step();
    chk("lb_byte", b0.byte_op_o, 1);
    set_op(2'b10, 3'b101, 7'h20, 0, 0, 0, 0, 0, 0); step();
    chk("srai_ctrl", b0.alu_ctrl_o, 9);
    set_op(2'b10, 3'b101, 7'h00, 1, 0, 0, 0, 0, 0); step();
    chk("srl_ctrl", b0.alu_ctrl_o, 8);
    set_op(2'b10, 3'b000, 7'h20, 0, 0, 0, 0, 0, 0); step();
    chk("addi_ctrl", b0.alu_ctrl_o, 0);
    set_op(2'b00, 3'b000, 7'h00, 1, 0, 1, 0, 0, 0); step();
    chk("jal_pc", b0.pc_src_o, 1);
    b0.in_valid = 0; step();
    chk("idle_valid", b0.out_valid, 0);

    // DIV: stage held for 8 cycles.
    set_op(2'b10, 3'b100, 7'h01, 1, 0, 0, 0, 0, 0); b0.in_valid = 1; step();
    b0.in_valid = 0;
    chk("div_start", b0.mdu_start_o, 1);
    n = 0;
    while (!b0.in_ready && n < 20) begin
      n++;
      step();
    end
    chk("div_stall_cycles", n, 8);
    chk("div_valid", b0.out_valid, 1);
    chk("div_ctrl", b0.alu_ctrl_o, 20);
    step();

    // Back-pressure then streaming.
    b0.out_ready = 0;
    set_op(2'b10, 3'b100, 7'h00, 1, 0, 0, 0, 0, 0); b0.in_valid = 1; step();
    set_op(2'b10, 3'b110, 7'h00, 1, 0, 0, 0, 0, 0);
    repeat (3) begin
      chk("bp_ctrl", b0.alu_ctrl_o, 4);
      chk("bp_in_ready", b0.in_ready, 0);
      step();
    end
    b0.out_ready = 1; step();
    chk("stream_or", b0.alu_ctrl_o, 3);
    set_op(2'b10, 3'b111, 7'h00, 1, 0, 0, 0, 0, 0); step();
    chk("stream_and", b0.alu_ctrl_o, 2);
    chk("stream_valid", b0.out_valid, 1);
    b0.in_valid = 0; step();

    // Flush at cnt=3 of a divide.
    set_op(2'b10, 3'b101, 7'h01, 1, 0, 0, 0, 0, 0); b0.in_valid = 1; step();
    b0.in_valid = 0;
    repeat (4) step();
    flush = 1; step();
    flush = 0;
    chk("flush_abort", b0.mdu_abort_o, 1);
    chk("flush_valid", b0.out_valid, 0);
    seen = 0;
    repeat (10) begin
      step();
      if (b0.out_valid) seen++;
    end
    chk("flush_no_valid", seen, 0);

    // Asynchronous reset in the middle of a multiply.
    set_op(2'b10, 3'b000, 7'h01, 1, 0, 0, 0, 0, 0); b0.in_valid = 1; step();
    b0.in_valid = 0;
    chk("mul_ctrl_reg", b0.alu_ctrl_o, 16);
    chk("mul_start", b0.mdu_start_o, 1);
    rst_n = 0;
    #1;
    chk("rstmid_ctrl", b0.alu_ctrl_o, 0);
    chk("rstmid_start", b0.mdu_start_o, 0);
    chk("rstmid_abort", b0.mdu_abort_o, 0);
    chk("rstmid_valid", b0.out_valid, 0);
    step(); step();
    rst_n = 1;
    step();

    // MUL encoding on the build without the M extension.
    set_op(2'b10, 3'b000, 7'h01, 1, 0, 0, 0, 0, 0); b0.in_valid = 1; step();
    b0.in_valid = 0;
    chk("nom_valid", b1.out_valid, 1);
    chk("nom_ill", b1.illegal_o, 1);
    chk("nom_ctrl", b1.alu_ctrl_o, 5'h1f);
    chk("nom_start", b1.mdu_start_o, 0);
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
